// File: rtl/fifo_win_sum_if.sv
// Stream interface for fifo_win_sum: input sample strobe and registered window-sum result.
// The master drives samples and consumes sums; the slave is the summer itself.
interface fifo_win_sum_if #(
    parameter int DW = 8,
    parameter int OW = 8
);
    logic          pi_flag;
    logic [DW-1:0] pi_data;
    logic          po_flag;
    logic [OW-1:0] po_sum;
    logic          po_last;

    modport master (
        output pi_flag, pi_data,
        input  po_flag, po_sum, po_last
    );

    modport slave (
        input  pi_flag, pi_data,
        output po_flag, po_sum, po_last
    );
endinterface

// File: rtl/fifo_win_sum.sv
// Vertical sliding-window summer over a ROWS x COLS raster stream, one-cycle latency.
// Optional macro FIFO_WIN_SUM_SAT_EN clamps the sum to 2^OW-1 instead of wrapping.
module fifo_win_sum #(
    parameter int DW   = 8,
    parameter int OW   = 8,
    parameter int WIN  = 3,
    parameter int COLS = 50,
    parameter int ROWS = 50
) (
    input logic               sys_clk,
    input logic               sys_rst,
    fifo_win_sum_if.slave     bus
);
    localparam int SW = DW + $clog2(WIN);
    localparam int XW = (SW > OW) ? SW : OW;
    localparam int HW = (WIN - 1) * DW;
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic [HW-1:0] line_mem [COLS];
    logic [HW-1:0] rd_entry;
    logic [HW-1:0] wr_entry;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [SW-1:0] sum;
    logic [OW-1:0] sum_rs;
    logic          accept;
    logic          col_wrap;
    logic          row_wrap;

    assign accept   = bus.pi_flag && !sys_rst;
    assign col_wrap = (col_cnt == CW'(COLS - 1));
    assign row_wrap = (row_cnt == RW'(ROWS - 1));
    assign rd_entry = line_mem[col_cnt];

    // h[0] (row just above) lives in the low DW bits; shifting left ages every sample by one row.
    generate
        if (WIN == 2) begin : g_hist1
            assign wr_entry = bus.pi_data;
        end else begin : g_histn
            assign wr_entry = {rd_entry[HW-DW-1:0], bus.pi_data};
        end
    endgenerate

    always_comb begin
        sum = SW'(bus.pi_data);
        for (int i = 0; i < WIN - 1; i++) begin
            sum = sum + SW'(rd_entry[i*DW +: DW]);
        end
    end

`ifdef FIFO_WIN_SUM_SAT_EN
    always_comb begin
        sum_rs = OW'(sum);
        if (XW'(sum) > XW'({OW{1'b1}})) begin
            sum_rs = {OW{1'b1}};
        end
    end
`else
    assign sum_rs = OW'(sum);
`endif

    // History is never reset: the fill rows after any reset overwrite it before it is summed.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            line_mem[col_cnt] <= wr_entry;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            col_cnt     <= '0;
            row_cnt     <= '0;
            bus.po_flag <= 1'b0;
            bus.po_sum  <= '0;
            bus.po_last <= 1'b0;
        end else begin
            bus.po_flag <= 1'b0;
            bus.po_last <= 1'b0;
            if (accept) begin
                if (row_cnt >= RW'(WIN - 1)) begin
                    bus.po_flag <= 1'b1;
                    bus.po_sum  <= sum_rs;
                    bus.po_last <= col_wrap && row_wrap;
                end
                if (col_wrap) begin
                    col_cnt <= '0;
                    row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_win_sum.sv
// Scoreboard bench for fifo_win_sum (DW=8, OW=8, WIN=3, COLS=4, ROWS=5).
// Driver pushes hand-derived expected sums with their due cycle; a negedge monitor pops and compares.
module tb_fifo_win_sum;
    localparam int DW = 8, OW = 8, WIN = 3, COLS = 4, ROWS = 5;
    localparam int FRAME = COLS * ROWS;
    localparam int FILL  = (WIN - 1) * COLS;

    typedef struct {
        logic [OW-1:0] sum;
        logic          last;
        int            cyc;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   k       = 0;
    logic [OW-1:0] hold = '0;
    exp_t q[$];

    fifo_win_sum_if #(.DW(DW), .OW(OW)) bus ();

    fifo_win_sum #(.DW(DW), .OW(OW), .WIN(WIN), .COLS(COLS), .ROWS(ROWS)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the queue head in value, po_last and arrival cycle.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (bus.po_flag) begin
                if (q.size() == 0) begin
                    check("unexpected_po_flag", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("po_sum", int'(bus.po_sum), int'(e.sum));
                    check("po_last", int'(bus.po_last), int'(e.last));
                    check("latency_cycle", cyc, e.cyc);
                    hold = e.sum;
                end
            end else begin
                check("po_last_idle", int'(bus.po_last), 0);
                check("po_sum_hold", int'(bus.po_sum), int'(hold));
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    check("missing_po_flag", 0, 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; DUT samples on the next posedge, result due one cycle later.
    task automatic send(input logic [DW-1:0] d, input int gap, input logic emit,
                        input logic [OW-1:0] es, input logic el);
        exp_t e;
        bus.pi_flag = 1'b1;
        bus.pi_data = d;
        if (emit) begin
            e.sum  = es;
            e.last = el;
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
        @(posedge sys_clk); #1;
        bus.pi_flag = 1'b0;
        repeat (gap - 1) begin
            @(posedge sys_clk); #1;
        end
    endtask

    // Constant-data stream: first FILL strobes of each frame are silent, last one carries po_last.
    task automatic send_const(input logic [DW-1:0] d, input int n, input int gap,
                              input logic [OW-1:0] es);
        for (int i = 0; i < n; i++) begin
            send(d, gap, (k % FRAME) >= FILL, es, (k % FRAME) == FRAME - 1);
            k++;
        end
    endtask

    task automatic do_reset(input logic flag_during);
        sys_rst     = 1'b1;
        bus.pi_flag = flag_during;
        bus.pi_data = 8'd99;
        @(posedge sys_clk); #1;
        sys_rst     = 1'b0;
        bus.pi_flag = 1'b0;
        hold        = '0;
        k           = 0;
    endtask

    task automatic drain();
        repeat (4) begin
            @(posedge sys_clk); #1;
        end
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        bus.pi_flag = 1'b0;
        bus.pi_data = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        do_reset(1'b0);
        check("reset_po_flag", int'(bus.po_flag), 0);
        check("reset_po_sum", int'(bus.po_sum), 0);
        check("reset_po_last", int'(bus.po_last), 0);

        // 1: spaced fill of ones
        send_const(8'd1, 20, 3, 8'd3);
        drain();

        // 2: ramp 10*row+col; sum over rows r-2..r is 30*r+3*c-30 (33 at r2c1, 99 at r4c3)
        do_reset(1'b0);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                send(8'(10 * r + c), 2, r >= WIN - 1, 8'(30 * r + 3 * c - 30),
                     (r == ROWS - 1) && (c == COLS - 1));
            end
        end
        drain();

        // 3: overflow, 600 wraps to 88 or clamps to 255
        do_reset(1'b0);
`ifdef FIFO_WIN_SUM_SAT_EN
        send_const(8'd200, 20, 1, 8'd255);
`else
        send_const(8'd200, 20, 1, 8'd88);
`endif
        drain();

        // 4: back-to-back ones
        do_reset(1'b0);
        send_const(8'd1, 20, 1, 8'd3);
        drain();

        // 5: mid-frame reset with a strobe held during reset, then refill
        do_reset(1'b0);
        send_const(8'd7, 10, 2, 8'd21);
        drain();
        do_reset(1'b1);
        send_const(8'd5, 20, 1, 8'd15);
        drain();

        // 6: two frames back-to-back
        do_reset(1'b0);
        send_const(8'd2, 40, 1, 8'd6);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
